xperm8_scatter_rv64: RTL and testbench

//  Iterative byte-scatter unit: inverse direction of the xperm8 gather. Source byte i of rs2
//  is written to destination byte rs1[8*i+:8]. When rs1 is a permutation, xperm8(rd,rs1)==rs2.

---
 rtl/xperm8_pkg.sv | 13 +
 rtl/xperm8_scatter_lane.sv | 12 +
 rtl/xperm8_scatter_rv64.sv | 122 ++++++++++++
 tb/tb_xperm8_scatter_rv64.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xperm8_pkg.sv
// Shared widths and state encoding for the xperm8 byte-scatter helper unit.
package xperm8_pkg;
  localparam int XLEN   = 64;
  localparam int NBYTES = XLEN / 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;
endpackage

// File: rtl/xperm8_scatter_lane.sv
// One source lane: decodes its index byte into a one-hot destination write enable.
module xperm8_scatter_lane
  import xperm8_pkg::*;
(
  input  logic [7:0]        idx,
  output logic [NBYTES-1:0] we,
  output logic              out_of_range
);
  // All eight index bits take part, so e.g. 0x08 and 0xFF are both dropped.
  assign out_of_range = (idx >= 8'(NBYTES));
  assign we           = out_of_range ? '0 : (NBYTES'(1) << idx[IDX_W-1:0]);
endmodule

// File: rtl/xperm8_scatter_rv64.sv
// Iterative byte scatter: source byte i of rs2 lands in rd byte rs1[8*i+:8],
// BYTES_PER_CYCLE lanes per cycle, highest lane winning on collisions.
module xperm8_scatter_rv64
  import xperm8_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            bijective
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - BYTES_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BYTES_PER_CYCLE);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [NBYTES-1:0][7:0]  idx_q, data_q;
  logic [NBYTES-1:0][7:0]  rd_q, rd_nxt;
  logic [NBYTES-1:0]       used_q, used_nxt;
  logic                    coll_q, coll_nxt;
  logic                    err_q, err_nxt;
  logic                    accept;

  logic [7:0]              lane_data [BYTES_PER_CYCLE];
  logic [NBYTES-1:0]       lane_we   [BYTES_PER_CYCLE];
  logic                    lane_oor  [BYTES_PER_CYCLE];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign rd        = rd_q;
  assign bijective = ~coll_q & ~err_q & (&used_q);

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    logic [CNT_W-1:0] sel;
    assign sel          = cnt_q + CNT_W'(g);
    assign lane_data[g] = data_q[sel];

    xperm8_scatter_lane u_lane (
      .idx          (idx_q[sel]),
      .we           (lane_we[g]),
      .out_of_range (lane_oor[g])
    );
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt_q;
    rd_nxt    = rd_q;
    used_nxt  = used_q;
    coll_nxt  = coll_q;
    err_nxt   = err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
          rd_nxt    = '0;
          used_nxt  = '0;
          coll_nxt  = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      BUSY: begin
        // Ascending lane order makes the highest lane the last writer of each byte.
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
          for (int d = 0; d < NBYTES; d++) begin
            if (lane_we[g][d]) begin
              if (used_nxt[d]) coll_nxt = 1'b1;
              used_nxt[d] = 1'b1;
              rd_nxt[d]   = lane_data[g];
            end
          end
          if (lane_oor[g]) err_nxt = 1'b1;
        end
        if (cnt_q == LAST_CNT) state_nxt = DONE;
        else                   cnt_nxt   = cnt_q + CNT_STEP;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      rd_q   <= '0;
      used_q <= '0;
      coll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      rd_q   <= rd_nxt;
      used_q <= used_nxt;
      coll_q <= coll_nxt;
      err_q  <= err_nxt;
    end
  end

  // NOTE: operand captures need no reset; they are always loaded before BUSY reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= rs1;
      data_q <= rs2;
    end
  end
endmodule

// File: tb/tb_xperm8_scatter_rv64.sv
// Self-checking bench: four instances (1,2,4,8 lanes per cycle) driven in lockstep
// and compared against a byte-array reference model of the scatter.
module tb_xperm8_scatter_rv64;
  localparam int NINST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, kill, out_ready;
  logic [63:0] rs1, rs2;

  logic        ir [NINST];
  logic        ov [NINST];
  logic        bj [NINST];
  logic [63:0] rdo [NINST];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NINST; k++) begin : g_dut
    xperm8_scatter_rv64 #(.BYTES_PER_CYCLE(1 << k)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[k]),
      .rs1       (rs1),
      .rs2       (rs2),
      .kill      (kill),
      .out_valid (ov[k]),
      .out_ready (out_ready),
      .rd        (rdo[k]),
      .bijective (bj[k])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: walk source bytes in order; a later byte overwrites an earlier one.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic bij);
    logic [7:0] res [8];
    int         hits [8];
    bij = 1'b1;
    for (int d = 0; d < 8; d++) begin res[d] = 8'h00; hits[d] = 0; end
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = int'(a[8*i +: 8]);
      if (idx < 8) begin
        res[idx] = b[8*i +: 8];
        hits[idx]++;
      end else begin
        bij = 1'b0;
      end
    end
    for (int d = 0; d < 8; d++) begin
      r[8*d +: 8] = res[d];
      if (hits[d] != 1) bij = 1'b0;
    end
  endfunction

  function automatic logic [63:0] xperm8(input logic [63:0] data, input logic [63:0] idx);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      int j;
      j = int'(idx[8*i +: 8]);
      r[8*i +: 8] = (j < 8) ? data[8*j +: 8] : 8'h00;
    end
    return r;
  endfunction

  function automatic logic all_ready();
    logic r;
    r = 1'b1;
    for (int k = 0; k < NINST; k++) r &= ir[k];
    return r;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!all_ready() && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!all_ready()) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit roundtrip);
    logic [63:0] exp_rd;
    logic        exp_bij;
    bit          seen [NINST];
    int          lat [NINST];
    logic [63:0] got_rd [NINST];
    logic        got_bij [NINST];
    model(a, b, exp_rd, exp_bij);
    wait_idle(tag);
    for (int k = 0; k < NINST; k++) seen[k] = 1'b0;
    rs1 = a;
    rs2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NINST; k++) begin
        if (ov[k] && !seen[k]) begin
          seen[k]    = 1'b1;
          lat[k]     = cyc;
          got_rd[k]  = rdo[k];
          got_bij[k] = bj[k];
        end
      end
    end
    for (int k = 0; k < NINST; k++) begin
      if (!seen[k]) begin
        check($sformatf("%s_bpc%0d_timeout", tag, 1 << k), 64'd0, 64'd1);
      end else begin
        check($sformatf("%s_bpc%0d_rd", tag, 1 << k), got_rd[k], exp_rd);
        check($sformatf("%s_bpc%0d_bij", tag, 1 << k), 64'(got_bij[k]), 64'(exp_bij));
        check($sformatf("%s_bpc%0d_lat", tag, 1 << k), 64'(lat[k]), 64'(8 >> k));
        if (roundtrip)
          check($sformatf("%s_bpc%0d_rt", tag, 1 << k), xperm8(got_rd[k], a), b);
      end
    end
  endtask

  function automatic logic [63:0] rand_perm();
    logic [7:0] p [8];
    logic [63:0] r;
    for (int i = 0; i < 8; i++) p[i] = 8'(i);
    for (int i = 7; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = int'($urandom_range(0, i));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 8; i++) r[8*i +: 8] = p[i];
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("%s_bpc%0d_rd", tag, 1 << k), rdo[k], 64'd0);
      check($sformatf("%s_bpc%0d_bij", tag, 1 << k), 64'(bj[k]), 64'd0);
      check($sformatf("%s_bpc%0d_ov", tag, 1 << k), 64'(ov[k]), 64'd0);
      check($sformatf("%s_bpc%0d_ir", tag, 1 << k), 64'(ir[k]), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] held;
    int          n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b1;
    rs1       = '0;
    rs2       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_txn("reverse",  64'h0001020304050607, 64'h8877665544332211, 1'b1);
    run_txn("identity", 64'h0706050403020100, 64'hDEADBEEFCAFEF00D, 1'b1);
    run_txn("collide",  64'h0000000000000000, 64'h8877665544332211, 1'b0);
    run_txn("oor",      64'h0706050403020108, 64'h8877665544332211, 1'b0);
    run_txn("allones",  64'hFFFFFFFFFFFFFFFF, 64'h8877665544332211, 1'b0);

    for (int t = 0; t < 12; t++)
      run_txn($sformatf("perm%0d", t), rand_perm(), {$urandom, $urandom}, 1'b1);

    for (int t = 0; t < 6; t++) begin
      logic [63:0] a;
      for (int i = 0; i < 8; i++) a[8*i +: 8] = 8'($urandom_range(0, 9));
      run_txn($sformatf("mixed%0d", t), a, {$urandom, $urandom}, 1'b0);
    end

    // Backpressure: consumer stalls for 10 cycles; a fresh request must be ignored meanwhile.
    wait_idle("bp");
    out_ready = 1'b0;
    rs1 = 64'h0001020304050607;
    rs2 = 64'h8877665544332211;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!ov[0] && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_ov_seen", 64'(ov[0]), 64'd1);
    held = rdo[0];
    check("bp_rd", held, 64'h1122334455667788);
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_ov_c%0d", c), 64'(ov[0]), 64'd1);
      check($sformatf("bp_rd_c%0d", c), rdo[0], held);
      check($sformatf("bp_ir_c%0d", c), 64'(ir[0]), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", 64'(ov[0]), 64'd0);
    check("bp_release_ir", 64'(ir[0]), 64'd1);

    // Kill sampled on the third BUSY edge: every instance returns to IDLE with no result.
    wait_idle("kill");
    out_ready = 1'b0;
    rs1 = 64'h0706050403020100;
    rs2 = 64'h0123456789ABCDEF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("kill_bpc%0d_ov", 1 << k), 64'(ov[k]), 64'd0);
      check($sformatf("kill_bpc%0d_ir", 1 << k), 64'(ir[k]), 64'd1);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (ov[0] || ov[3]) n++;
    end
    check("kill_no_ov", 64'(n), 64'd0);

    // Asynchronous reset in the middle of BUSY.
    rs1 = 64'h0001020304050607;
    rs2 = 64'h8877665544332211;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_txn("post_rst", 64'h0001020304050607, 64'h8877665544332211, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
